multi_edge_detector: RTL and testbench

MULTI_EDGE_DETECTOR -- requirements
Module: multi_edge_detector

---
 rtl/multi_edge_detector.sv | 122 ++++++++++++
 tb/tb_multi_edge_detector.sv | 270 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/multi_edge_detector.sv
// Per-channel synchronise -> optional debounce -> edge detect -> sticky flag.
// The top module only fans lanes out; every lane is independent.
module multi_edge_detector #(
  parameter int CHANNELS        = 4,
  parameter int SYNC_STAGES     = 2,
  parameter int DEBOUNCE_CYCLES = 0
) (
  input  logic                  outclk,
  input  logic                  reset,
  input  logic [CHANNELS-1:0]   async_sig,
  input  logic [2*CHANNELS-1:0] edge_sel,
  input  logic [CHANNELS-1:0]   flag_clr,
  output logic [CHANNELS-1:0]   out_sync_sig,
  output logic [CHANNELS-1:0]   pulse_out,
  output logic [CHANNELS-1:0]   flag_out,
  output logic                  irq
);

  for (genvar c = 0; c < CHANNELS; c++) begin : g_lane
    med_lane #(
      .SYNC_STAGES    (SYNC_STAGES),
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_lane (
      .gclk   (outclk),
      .grst_n (reset),
      .async_i(async_sig[c]),
      .sel_i  (edge_sel[2*c +: 2]),
      .clr_i  (flag_clr[c]),
      .level_o(out_sync_sig[c]),
      .pulse_o(pulse_out[c]),
      .flag_o (flag_out[c])
    );
  end

  assign irq = |flag_out;

endmodule

// One channel: sync chain, glitch filter, edge pulse and sticky flag.
module med_lane #(
  parameter int SYNC_STAGES     = 2,
  parameter int DEBOUNCE_CYCLES = 0
) (
  input  logic       gclk,
  input  logic       grst_n,
  input  logic       async_i,
  input  logic [1:0] sel_i,
  input  logic       clr_i,
  output logic       level_o,
  output logic       pulse_o,
  output logic       flag_o
);

  logic [SYNC_STAGES-1:0] sync_q, sync_d;
  logic s, f;
  logic p_q, p_d;
  logic pulse_q, pulse_d;
  logic flag_q, flag_d;
  logic rise, fall;

  always_comb sync_d = {sync_q[SYNC_STAGES-2:0], async_i};
  assign s = sync_q[SYNC_STAGES-1];

  if (DEBOUNCE_CYCLES == 0) begin : g_nodb
    assign f = s;
  end else begin : g_db
    localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CW-1:0] LAST = CW'(DEBOUNCE_CYCLES - 1);
    logic [CW-1:0] cnt_q, cnt_d;
    logic f_q, f_d;

    // Count consecutive mismatch cycles; any agreement restarts the window.
    always_comb begin
      cnt_d = '0;
      f_d   = f_q;
      if (s != f_q) begin
        if (cnt_q == LAST) f_d = s;
        else               cnt_d = cnt_q + 1'b1;
      end
    end

    always_ff @(posedge gclk or negedge grst_n) begin
      if (!grst_n) begin
        cnt_q <= '0;
        f_q   <= 1'b0;
      end else begin
        cnt_q <= cnt_d;
        f_q   <= f_d;
      end
    end

    assign f = f_q;
  end

  always_comb begin
    p_d     = f;
    rise    = f & ~p_q;
    fall    = ~f & p_q;
    pulse_d = (rise & sel_i[0]) | (fall & sel_i[1]);
    // A new pulse beats a simultaneous clear.
    flag_d  = pulse_q | (flag_q & ~clr_i);
  end

  always_ff @(posedge gclk or negedge grst_n) begin
    if (!grst_n) begin
      sync_q  <= '0;
      p_q     <= 1'b0;
      pulse_q <= 1'b0;
      flag_q  <= 1'b0;
    end else begin
      sync_q  <= sync_d;
      p_q     <= p_d;
      pulse_q <= pulse_d;
      flag_q  <= flag_d;
    end
  end

  assign level_o = f;
  assign pulse_o = pulse_q;
  assign flag_o  = flag_q;

endmodule

// File: tb/tb_multi_edge_detector.sv
// Bench for multi_edge_detector: a D=0 and a D=4 instance share stimulus and
// are checked against a history-based model plus fixed vectors.
module tb_multi_edge_detector;

  localparam int CH = 4;
  localparam int SS = 2;

  logic outclk = 1'b0;
  logic reset;
  logic [CH-1:0]   async_sig, flag_clr;
  logic [2*CH-1:0] edge_sel;
  logic [CH-1:0]   sync0, pulse0, flag0, sync4, pulse4, flag4;
  logic            irq0, irq4;

  int n_chk  = 0;
  int n_fail = 0;

  // Model: per instance/channel histories of raw samples and synchronised level.
  bit [7:0] ahist[2][CH];
  bit [7:0] shist[2][CH];
  bit       mF[2][CH], mP[2][CH], mpu[2][CH], mfl[2][CH];

  multi_edge_detector #(.CHANNELS(CH), .SYNC_STAGES(SS), .DEBOUNCE_CYCLES(0)) dut0 (
    .outclk(outclk), .reset(reset), .async_sig(async_sig), .edge_sel(edge_sel),
    .flag_clr(flag_clr), .out_sync_sig(sync0), .pulse_out(pulse0),
    .flag_out(flag0), .irq(irq0));

  multi_edge_detector #(.CHANNELS(CH), .SYNC_STAGES(SS), .DEBOUNCE_CYCLES(4)) dut4 (
    .outclk(outclk), .reset(reset), .async_sig(async_sig), .edge_sel(edge_sel),
    .flag_clr(flag_clr), .out_sync_sig(sync4), .pulse_out(pulse4),
    .flag_out(flag4), .irq(irq4));

  always #5 outclk = ~outclk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, n_chk=%0d", n_chk);
    $fatal(1);
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int m = 0; m < 2; m++)
      for (int c = 0; c < CH; c++) begin
        ahist[m][c] = '0; shist[m][c] = '0;
        mF[m][c] = 0; mP[m][c] = 0; mpu[m][c] = 0; mfl[m][c] = 0;
      end
  endtask

  // Filtered level flips once the last D pre-edge levels all disagree with it.
  task automatic model_step();
    for (int m = 0; m < 2; m++)
      for (int c = 0; c < CH; c++) begin
        int       d;
        bit       s_old, f_old, f_new;
        bit [7:0] mask;
        d     = (m == 1) ? 4 : 0;
        s_old = ahist[m][c][SS-1];
        shist[m][c] = {shist[m][c][6:0], s_old};
        ahist[m][c] = {ahist[m][c][6:0], async_sig[c]};
        f_old = mF[m][c];
        if (d == 0) f_new = ahist[m][c][SS-1];
        else begin
          mask  = 8'((1 << d) - 1);
          f_new = (((shist[m][c] ^ {8{~f_old}}) & mask) == 8'h00) ? ~f_old : f_old;
        end
        mfl[m][c] = mpu[m][c] | (mfl[m][c] & ~flag_clr[c]);
        mpu[m][c] = (f_old & ~mP[m][c] & edge_sel[2*c]) |
                    (~f_old & mP[m][c] & edge_sel[2*c+1]);
        mP[m][c]  = f_old;
        mF[m][c]  = f_new;
      end
  endtask

  task automatic compare_model();
    logic [1:0][CH-1:0] es, ep, ef;
    for (int m = 0; m < 2; m++)
      for (int c = 0; c < CH; c++) begin
        es[m][c] = mF[m][c]; ep[m][c] = mpu[m][c]; ef[m][c] = mfl[m][c];
      end
    chk("model d0 out_sync_sig", 32'(sync0),  32'(es[0]));
    chk("model d0 pulse_out",    32'(pulse0), 32'(ep[0]));
    chk("model d0 flag_out",     32'(flag0),  32'(ef[0]));
    chk("model d0 irq",          32'(irq0),   32'(|ef[0]));
    chk("model d4 out_sync_sig", 32'(sync4),  32'(es[1]));
    chk("model d4 pulse_out",    32'(pulse4), 32'(ep[1]));
    chk("model d4 flag_out",     32'(flag4),  32'(ef[1]));
    chk("model d4 irq",          32'(irq4),   32'(|ef[1]));
  endtask

  // Inputs always change 2 time units after a rising edge; sampling happens there too.
  task automatic step();
    @(posedge outclk);
    if (reset) model_step();
    #2;
    compare_model();
  endtask

  task automatic settle(input logic [CH-1:0] a, input logic [2*CH-1:0] sel);
    async_sig = a;
    edge_sel  = sel;
    flag_clr  = '1;
    repeat (12) step();
    flag_clr  = '0;
  endtask

  typedef struct {
    logic [3:0] a;
    logic [3:0] clr;
    logic [3:0] s;
    logic [3:0] p;
    logic [3:0] f;
    logic       irq;
  } vec_t;

  vec_t tbl[14];

  initial begin
    int cnt, at;
    // ch0 rising only, ch1 off; D=0 instance
    tbl[0]  = '{4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 1'b0};
    tbl[1]  = '{4'h1, 4'h0, 4'h0, 4'h0, 4'h0, 1'b0};
    tbl[2]  = '{4'h1, 4'h0, 4'h1, 4'h0, 4'h0, 1'b0};
    tbl[3]  = '{4'h1, 4'h0, 4'h1, 4'h1, 4'h0, 1'b0};
    tbl[4]  = '{4'h1, 4'h0, 4'h1, 4'h0, 4'h1, 1'b1};
    tbl[5]  = '{4'h1, 4'h0, 4'h1, 4'h0, 4'h1, 1'b1};
    tbl[6]  = '{4'h0, 4'h0, 4'h1, 4'h0, 4'h1, 1'b1};
    tbl[7]  = '{4'h0, 4'h0, 4'h0, 4'h0, 4'h1, 1'b1};
    tbl[8]  = '{4'h0, 4'h0, 4'h0, 4'h0, 4'h1, 1'b1};
    tbl[9]  = '{4'h0, 4'h1, 4'h0, 4'h0, 4'h0, 1'b0};
    tbl[10] = '{4'h3, 4'h0, 4'h0, 4'h0, 4'h0, 1'b0};
    tbl[11] = '{4'h3, 4'h0, 4'h3, 4'h0, 4'h0, 1'b0};
    tbl[12] = '{4'h3, 4'h0, 4'h3, 4'h1, 4'h0, 1'b0};
    tbl[13] = '{4'h3, 4'h0, 4'h3, 4'h0, 4'h1, 1'b1};

    reset = 1'b0; async_sig = '0; edge_sel = '0; flag_clr = '0;
    model_reset();
    #1;
    chk("reset d0 out_sync_sig", 32'(sync0), 0);
    chk("reset d0 pulse_out",    32'(pulse0), 0);
    chk("reset d4 flag_out",     32'(flag4), 0);
    chk("reset irq",             32'({irq0, irq4}), 0);
    repeat (2) step();
    reset = 1'b1;

    edge_sel = 8'h01;
    for (int i = 0; i < 14; i++) begin
      async_sig = tbl[i].a;
      flag_clr  = tbl[i].clr;
      step();
      chk($sformatf("vec%0d out_sync_sig", i), 32'(sync0),  32'(tbl[i].s));
      chk($sformatf("vec%0d pulse_out", i),    32'(pulse0), 32'(tbl[i].p));
      chk($sformatf("vec%0d flag_out", i),     32'(flag0),  32'(tbl[i].f));
      chk($sformatf("vec%0d irq", i),          32'(irq0),   32'(tbl[i].irq));
    end
    flag_clr = '0;

    // Glitch rejection then a real rise and fall on ch1 with D=4
    settle(4'h0, 8'h0C);
    for (int k = 1; k <= 13; k++) begin
      async_sig = (k <= 3) ? 4'h2 : 4'h0;
      step();
      chk("glitch d4 pulse[1]", 32'(pulse4[1]), 0);
      chk("glitch d4 sync[1]",  32'(sync4[1]), 0);
    end
    async_sig = 4'h2;
    for (int k = 1; k <= 12; k++) begin
      step();
      chk($sformatf("d4 rise k%0d sync[1]", k),  32'(sync4[1]),  32'(k >= 6));
      chk($sformatf("d4 rise k%0d pulse[1]", k), 32'(pulse4[1]), 32'(k == 7));
    end
    async_sig = 4'h0;
    for (int k = 1; k <= 12; k++) begin
      step();
      chk($sformatf("d4 fall k%0d sync[1]", k),  32'(sync4[1]),  32'(k < 6));
      chk($sformatf("d4 fall k%0d pulse[1]", k), 32'(pulse4[1]), 32'(k == 7));
    end

    // Falling-only mode on ch2, then mode off
    settle(4'h0, 8'h20);
    cnt = 0; at = 0;
    for (int k = 1; k <= 20; k++) begin
      async_sig = (k <= 5) ? 4'h4 : 4'h0;
      step();
      if (pulse0[2]) begin cnt++; at = k; end
    end
    chk("fall-only pulse count", 32'(cnt), 1);
    chk("fall-only pulse cycle", 32'(at), 8);
    chk("fall-only flag[2]",     32'(flag0[2]), 1);
    settle(4'h0, 8'h00);
    cnt = 0;
    for (int k = 1; k <= 20; k++) begin
      async_sig = (k <= 5) ? 4'h4 : 4'h0;
      step();
      if (k == 3) chk("mode off sync tracks", 32'(sync0[2]), 1);
      if (pulse0[2]) cnt++;
    end
    chk("mode off pulse count", 32'(cnt), 0);
    chk("mode off flag[2]",     32'(flag0[2]), 0);

    // Set beats a coincident clear
    settle(4'h0, 8'h01);
    async_sig = 4'h1;
    repeat (3) step();
    chk("clr test pulse[0]", 32'(pulse0[0]), 1);
    flag_clr = 4'h1;
    step();
    chk("set wins flag[0]", 32'(flag0[0]), 1);
    step();
    chk("clear flag[0]", 32'(flag0[0]), 0);
    chk("clear irq",     32'(irq0), 0);
    flag_clr = 4'h0;

    // Reset in the middle of a debounce count, input held high through release
    settle(4'h0, 8'h03);
    async_sig = 4'h1;
    repeat (5) step();
    reset = 1'b0;
    model_reset();
    #1;
    chk("mid-reset d4 outputs", 32'({sync4, pulse4, flag4, irq4}), 0);
    chk("mid-reset d0 outputs", 32'({sync0, pulse0, flag0, irq0}), 0);
    repeat (3) step();
    reset = 1'b1;
    for (int k = 1; k <= 10; k++) begin
      step();
      chk($sformatf("post-reset k%0d sync[0]", k),  32'(sync4[0]),  32'(k >= 6));
      chk($sformatf("post-reset k%0d pulse[0]", k), 32'(pulse4[0]), 32'(k == 7));
    end

    // All channels together
    settle(4'h0, 8'hFF);
    async_sig = 4'hF;
    for (int k = 1; k <= 8; k++) begin
      step();
      chk($sformatf("all ch k%0d d0 pulse", k), 32'(pulse0), (k == 3) ? 32'hF : 32'h0);
      chk($sformatf("all ch k%0d d4 pulse", k), 32'(pulse4), (k == 7) ? 32'hF : 32'h0);
      if (k == 4) chk("all ch d0 flag", 32'(flag0), 32'hF);
      if (k == 8) chk("all ch d4 flag", 32'(flag4), 32'hF);
    end

    // Random activity against the model
    flag_clr = '0;
    for (int i = 0; i < 600; i++) begin
      for (int c = 0; c < CH; c++)
        if ($urandom_range(5) == 0) async_sig[c] = ~async_sig[c];
      if ($urandom_range(39) == 0) edge_sel = 8'($urandom);
      flag_clr = 4'($urandom) & 4'($urandom) & 4'($urandom);
      if (i == 300) begin
        reset = 1'b0;
        model_reset();
        #1;
        compare_model();
      end
      if (i == 303) reset = 1'b1;
      step();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
